// File: rtl/eth_mdio_responder_if.sv
// MDIO responder bus bundle: resolved line in, tri-state pair out, plus
// the register-0 mirror and the write-notification side channel.
interface eth_mdio_responder_if;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic [15:0] ctrl_o;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    modport slave  (input  mdio_i,
                    output mdio_o, mdio_t, ctrl_o, wr_valid, wr_addr, wr_data);
    modport master (output mdio_i,
                    input  mdio_o, mdio_t, ctrl_o, wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/eth_mdio_responder.sv
// Clause-22 MDIO PHY-side responder: preamble hunt, frame decode, 32x16
// register file with read-only ID registers and a self-clearing reg0 bit 15.
module eth_mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1622,
    parameter logic [15:0] REG0_RST = 16'h1140
) (
    input logic                 clk,
    input logic                 reset,
    eth_mdio_responder_if.slave bus
);
    typedef enum logic [3:0] {
        S_PRE, S_ST2, S_OP, S_PHY, S_REG, S_TA_W, S_WDATA, S_TA_R, S_RDATA, S_SKIP
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  pre_cnt;
    logic [3:0]  cnt;
    logic [4:0]  skip_rem;
    logic [10:0] hdr;
    logic [11:0] hdr_nxt;
    logic        ta_b1;
    logic [14:0] wsh;
    logic [15:0] wdata_full;
    logic [15:0] rsh;
    logic [15:0] rd_word, rd_sel;
    logic [4:0]  regad;
    logic [15:0] rf [32];
    logic        mdio_t_q, mdio_o_q, mdio_t_nxt, mdio_o_nxt;
    logic        wr_fire, wr_valid_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    // {OP, PHYAD, REGAD} including the bit being sampled this cycle
    assign hdr_nxt    = {hdr, bus.mdio_i};
    assign wdata_full = {wsh, bus.mdio_i};

    always_comb begin
        rd_sel = rf[hdr_nxt[4:0]];
        if (hdr_nxt[4:0] == 5'd2) rd_sel = PHY_ID1;
        if (hdr_nxt[4:0] == 5'd3) rd_sel = PHY_ID2;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_PRE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PRE:   if (!bus.mdio_i && pre_cnt[5]) state_nxt = S_ST2;
            S_ST2:   state_nxt = bus.mdio_i ? S_OP : S_PRE;
            S_OP:    if (cnt == 4'd1)
                         state_nxt = (hdr_nxt[1] ^ hdr_nxt[0]) ? S_PHY : S_PRE;
            S_PHY:   if (cnt == 4'd4) state_nxt = S_REG;
            S_REG:   if (cnt == 4'd4) begin
                         if (hdr_nxt[9:5] != PHY_ADDR)     state_nxt = S_SKIP;
                         else if (hdr_nxt[11:10] == 2'b10) state_nxt = S_TA_R;
                         else                              state_nxt = S_TA_W;
                     end
            S_TA_W:  if (cnt == 4'd1)
                         state_nxt = ({ta_b1, bus.mdio_i} == 2'b10) ? S_WDATA : S_SKIP;
            S_WDATA: if (cnt == 4'd15) state_nxt = S_PRE;
            S_TA_R:  if (cnt == 4'd1) state_nxt = S_RDATA;
            S_RDATA: if (cnt == 4'd15) state_nxt = S_PRE;
            S_SKIP:  if (skip_rem == 5'd1) state_nxt = S_PRE;
            default: state_nxt = S_PRE;
        endcase
    end

    // Next values of the registered bus outputs: drive 0 for TA bit 2,
    // then 16 data bits, releasing on the edge that samples data bit 0.
    always_comb begin
        mdio_t_nxt = 1'b1;
        mdio_o_nxt = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            S_TA_R: begin
                mdio_t_nxt = 1'b0;
                if (cnt == 4'd1) mdio_o_nxt = rd_word[15];
            end
            S_RDATA: if (cnt != 4'd15) begin
                mdio_t_nxt = 1'b0;
                mdio_o_nxt = rsh[15];
            end
            S_WDATA: wr_fire = (cnt == 4'd15) && (regad != 5'd2) && (regad != 5'd3);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt    <= '0;
            cnt        <= '0;
            skip_rem   <= '0;
            hdr        <= '0;
            ta_b1      <= 1'b0;
            wsh        <= '0;
            rsh        <= '0;
            rd_word    <= '0;
            regad      <= '0;
            mdio_t_q   <= 1'b1;
            mdio_o_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? REG0_RST : 16'h0000;
        end else begin
            mdio_t_q   <= mdio_t_nxt;
            mdio_o_q   <= mdio_o_nxt;
            wr_valid_q <= wr_fire;
            cnt        <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;

            // Counter only survives while hunting, so each frame needs a fresh preamble
            if (state != S_PRE)     pre_cnt <= '0;
            else if (!bus.mdio_i)   pre_cnt <= '0;
            else if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;

            if (state == S_OP || state == S_PHY || state == S_REG) hdr <= hdr_nxt[10:0];
            if (state == S_REG && cnt == 4'd4) begin
                regad   <= hdr_nxt[4:0];
                rd_word <= rd_sel;
            end
            if (state == S_TA_W) ta_b1 <= bus.mdio_i;
            if (state == S_WDATA) wsh <= wdata_full[14:0];

            if (state == S_TA_R && cnt == 4'd1) rsh <= {rd_word[14:0], 1'b0};
            else if (state == S_RDATA)          rsh <= {rsh[14:0], 1'b0};

            if (state_nxt == S_SKIP && state != S_SKIP)
                skip_rem <= (state == S_REG) ? 5'd18 : 5'd16;
            else if (state == S_SKIP)
                skip_rem <= skip_rem - 5'd1;

            if (rf[0][15]) rf[0][15] <= 1'b0;
            // Later assignment lets a completing write override the self-clear
            if (wr_fire) begin
                rf[regad] <= wdata_full;
                wr_addr_q <= regad;
                wr_data_q <= wdata_full;
            end
        end
    end

    assign bus.mdio_t   = mdio_t_q;
    assign bus.mdio_o   = mdio_o_q;
    assign bus.ctrl_o   = rf[0];
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_eth_mdio_responder.sv
// Directed bench for eth_mdio_responder: table of frames plus hand-written
// self-clear and reset-during-read sequences.
module tb_eth_mdio_responder;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic m_bit = 1'b1;

    eth_mdio_responder_if bus();
    // Resolved line: responder wins when driving, else the master / pull-up
    assign bus.mdio_i = bus.mdio_t ? m_bit : bus.mdio_o;

    eth_mdio_responder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [1:0]  ta;
        logic [15:0] d;
        int          ewr;
        logic [15:0] ectrl;
        logic [15:0] erd;
        int          etlow;
    } vec_t;

    vec_t        vq[$];
    int          n_chk = 0, n_fail = 0;
    int          wr_seen, tlow;
    logic [4:0]  wa;
    logic [15:0] wd, rd;
    logic        ta_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic b);
        m_bit = b;
        @(posedge clk);
        #1;
        if (bus.wr_valid) begin
            wr_seen++;
            wa = bus.wr_addr;
            wd = bus.wr_data;
        end
        if (!bus.mdio_t) tlow++;
    endtask

    // Gap of released cycles, two zeros to zero the ones counter, then the
    // preamble of exactly 'pre' ones and the header.
    task automatic send_hdr(input int pre, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra);
        wr_seen = 0;
        tlow    = 0;
        repeat (64) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        repeat (pre) tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        for (int i = 1; i >= 0; i--) tick(op[i]);
        for (int i = 4; i >= 0; i--) tick(phy[i]);
        for (int i = 4; i >= 0; i--) tick(ra[i]);
    endtask

    task automatic write_body(input logic [1:0] ta, input logic [15:0] d);
        tick(ta[1]);
        tick(ta[0]);
        for (int i = 15; i >= 0; i--) tick(d[i]);
    endtask

    task automatic read_body();
        rd   = '0;
        ta_o = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick(1'b1);
            if (k == 1)       ta_o = bus.mdio_o;
            else if (k <= 17) rd = {rd[14:0], bus.mdio_o};
        end
    endtask

    task automatic add(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d,
                       input int ewr, input logic [15:0] ectrl, input logic [15:0] erd,
                       input int etlow);
        vec_t v;
        v.pre = pre; v.op = op; v.phy = phy; v.ra = ra; v.ta = ta; v.d = d;
        v.ewr = ewr; v.ectrl = ectrl; v.erd = erd; v.etlow = etlow;
        vq.push_back(v);
    endtask

    initial begin
        //   pre op     phy   ra     ta     data      wr ctrl      rd        tlow
        add(32, 2'b01, 5'd3, 5'd0,  2'b10, 16'hABCD, 0, 16'h1140, 16'h0000, 0);
        add(32, 2'b01, 5'd1, 5'd0,  2'b10, 16'h3100, 1, 16'h3100, 16'h0000, 0);
        add(32, 2'b01, 5'd1, 5'd9,  2'b10, 16'h0000, 1, 16'h3100, 16'h0000, 0);
        add(32, 2'b01, 5'd1, 5'd0,  2'b10, 16'h3300, 1, 16'h3300, 16'h0000, 0);
        add(32, 2'b10, 5'd1, 5'd2,  2'b10, 16'h0000, 0, 16'h3300, 16'h0022, 17);
        add(32, 2'b10, 5'd1, 5'd3,  2'b10, 16'h0000, 0, 16'h3300, 16'h1622, 17);
        add(31, 2'b01, 5'd1, 5'd5,  2'b10, 16'hBEEF, 0, 16'h3300, 16'h0000, 0);
        add(32, 2'b01, 5'd1, 5'd5,  2'b10, 16'hBEEF, 1, 16'h3300, 16'h0000, 0);
        add(32, 2'b10, 5'd1, 5'd5,  2'b10, 16'h0000, 0, 16'h3300, 16'hBEEF, 17);
        add(32, 2'b01, 5'd1, 5'd2,  2'b10, 16'hFFFF, 0, 16'h3300, 16'h0000, 0);
        add(32, 2'b10, 5'd1, 5'd2,  2'b10, 16'h0000, 0, 16'h3300, 16'h0022, 17);
        add(32, 2'b01, 5'd1, 5'd5,  2'b11, 16'h1234, 0, 16'h3300, 16'h0000, 0);
        add(32, 2'b10, 5'd1, 5'd5,  2'b10, 16'h0000, 0, 16'h3300, 16'hBEEF, 17);
        add(32, 2'b10, 5'd3, 5'd5,  2'b10, 16'h0000, 0, 16'h3300, 16'h0000, 0);
        add(32, 2'b10, 5'd1, 5'd0,  2'b10, 16'h0000, 0, 16'h3300, 16'h3300, 17);
        add(32, 2'b10, 5'd1, 5'd9,  2'b10, 16'h0000, 0, 16'h3300, 16'h0000, 17);

        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset mdio_t",   bus.mdio_t,   1'b1);
        chk("reset mdio_o",   bus.mdio_o,   1'b0);
        chk("reset wr_valid", bus.wr_valid, 1'b0);
        chk("reset wr_addr",  bus.wr_addr,  5'd0);
        chk("reset wr_data",  bus.wr_data,  16'h0000);
        chk("reset ctrl_o",   bus.ctrl_o,   16'h1140);
        reset = 1'b0;

        foreach (vq[i]) begin
            send_hdr(vq[i].pre, vq[i].op, vq[i].phy, vq[i].ra);
            if (vq[i].op == 2'b10) read_body();
            else                   write_body(vq[i].ta, vq[i].d);
            chk($sformatf("v%0d wr_valid count", i), wr_seen, vq[i].ewr);
            if (vq[i].ewr > 0) begin
                chk($sformatf("v%0d wr_addr", i), wa, vq[i].ra);
                chk($sformatf("v%0d wr_data", i), wd, vq[i].d);
            end
            chk($sformatf("v%0d ctrl_o", i), bus.ctrl_o, vq[i].ectrl);
            chk($sformatf("v%0d mdio_t low cycles", i), tlow, vq[i].etlow);
            if (vq[i].etlow == 17) begin
                chk($sformatf("v%0d TA drive", i), ta_o, 1'b0);
                chk($sformatf("v%0d read data", i), rd, vq[i].erd);
            end
        end

        // Self-clearing reset bit: visible for exactly one cycle
        send_hdr(32, 2'b01, 5'd1, 5'd0);
        write_body(2'b10, 16'h8000);
        chk("selfclr wr_valid count", wr_seen, 1);
        chk("selfclr ctrl_o set", bus.ctrl_o, 16'h8000);
        tick(1'b1);
        chk("selfclr ctrl_o cleared", bus.ctrl_o, 16'h0000);
        send_hdr(32, 2'b10, 5'd1, 5'd0);
        read_body();
        chk("selfclr readback", rd, 16'h0000);
        chk("selfclr readback mdio_t low", tlow, 17);

        // Reset while driving data bit 7 of a reg9 read
        send_hdr(32, 2'b01, 5'd1, 5'd9);
        write_body(2'b10, 16'h5A5A);
        chk("midrd prewrite count", wr_seen, 1);
        send_hdr(32, 2'b10, 5'd1, 5'd9);
        for (int k = 1; k <= 10; k++) tick(1'b1);
        chk("midrd driving before reset", bus.mdio_t, 1'b0);
        reset = 1'b1;
        tick(1'b1);
        chk("midrd mdio_t after reset", bus.mdio_t, 1'b1);
        chk("midrd ctrl_o after reset", bus.ctrl_o, 16'h1140);
        reset = 1'b0;
        tick(1'b1);
        chk("midrd mdio_t stays released", bus.mdio_t, 1'b1);
        send_hdr(32, 2'b10, 5'd1, 5'd9);
        read_body();
        chk("midrd reg9 after reset", rd, 16'h0000);
        chk("midrd reread mdio_t low", tlow, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
